seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's BCD/hex-to-7-segment encoder.
- Samples a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and rebuilds the 4-bit value shown on each digit.
- Requires a pattern to be stable for STABLE consecutive clocks before it is accepted.
- Used as a display-bus monitor/scoreboard and as a front-end for reading back scanned displays.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE, 3, consecutive identical samples required before capture (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment lines, active-high, bit order {a,b,c,d,e,f,g} = seg[6:0].
- an  in  NDIG  digit enables, active-high, expected one-hot.
- digits  out  4*NDIG  decoded value per digit; digit i occupies digits[4i+3:4i].
- dig_valid  out  NDIG  bit i set once digit i has held a valid capture.
- upd  out  1  one-cycle pulse: a valid capture was written this cycle.
- err  out  1  one-cycle pulse: a stable pattern was not a legal glyph.
- upd_idx  out  clog2(NDIG) (min 1)  digit index for the current upd or err pulse.

Behaviour:
- Reset (async assert, sync deassert at the next edge): digits=0, dig_valid=0, upd=0, err=0, upd_idx=0, internal sample register=0, stability counter cnt=0.
- Sampling, every rising edge:
  - samp <= {an,seg}.
  - If an is not one-hot (zero or more than one bit): cnt <= 0.
  - Else if {an,seg} == samp: cnt <= min(cnt+1, STABLE).
  - Else: cnt <= 1.
- Capture condition, same edge: an is one-hot, {an,seg} == samp, and cnt == STABLE-1. cnt then saturates at STABLE, so there is exactly one capture per stable run.
- Latency: if inputs change just before edge k and then hold, the capture happens at edge k+STABLE-1. upd/err are high for the cycle after that edge. With the default STABLE=3, that is edge k+2.
- Capture action, with idx = encoded position of the single set bit of an:
  - Legal glyph: digits[idx] <= value; dig_valid[idx] <= 1; upd <= 1; upd_idx <= idx.
  - Illegal glyph: err <= 1; upd_idx <= idx; digits and dig_valid unchanged.
- upd and err are never both high. Both return to 0 on the edge after their pulse unless a new capture occurs.
- Legal glyphs, hex value -> seg[6:0]:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1111011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
  - Any other pattern, including all-off 0000000, is illegal.
- Re-capturing an identical value still pulses upd; no change filtering.
- A change on seg or an during counting restarts cnt at 1 (or 0 if an is not one-hot). No capture happens on the changing edge.
- Blanking gaps between digits (an = 0) reset cnt. A digit returning with the same glyph is captured again after STABLE cycles.
- dig_valid is sticky and is cleared only by reset.
- Reset mid-count: all state clears immediately, and no pulse is emitted.

Decomposition:
- Shared package seg7_pkg holds:
  - segment bit-order constants SEG_A..SEG_G;
  - glyph constants GLYPH_0..GLYPH_F (7-bit);
  - the hex-value-to-glyph table, shared with the encoder so both ends use one mapping.
- One combinational sub-module, seg7_glyph_decode: seg[6:0] in -> {legal, value[3:0]} out.
- The one-hot-to-index encoder and the counter stay in the top level.

Test Plan:
- Reset: hold rst_n=0 and drive seg/an freely -> digits=0, dig_valid=0, no upd/err. Release reset, drive an=0001, seg=1111001 for 3 clocks -> upd pulse at edge 2, upd_idx=0, digits[3:0]=3, dig_valid=0001.
- Full scan: cycle an through 0001/0010/0100/1000 with glyphs 0,1,A,F, 4 clocks each plus 1 blank clock between -> four upd pulses with idx 0..3; final digits=16'hFA10 (digit3..0 = F,A,1,0); dig_valid=1111.
- Glitch rejection: on an=0010, drive seg=1011011 for 2 clocks, then 1011111 for 3 clocks -> no pulse for the first pattern; one upd with digits[7:4]=6 at the third clock of the second pattern.
- Illegal pattern and bad enables: seg=0000001 on an=0100 for 3 clocks -> err pulse, upd_idx=2, digits[11:8] and dig_valid[2] unchanged. Then an=0110 with a legal glyph for 5 clocks -> no upd, no err.
- Saturation and repeat: hold an=1000, seg=1111111 for 10 clocks -> exactly one upd (digits[15:12]=8). Blank 1 clock, then re-present for 3 clocks -> a second upd.
- Async reset mid-count: assert rst_n=0 between clocks at count 2 -> outputs clear immediately without waiting for a clock edge, and no pulse appears after reset is released.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment bit order, glyph constants and hex-to-glyph table
//
// Purpose: one definition of the segment mapping, used by both the encoder and
//          the scan decoder so the two ends of the display bus cannot disagree.
// Contents: SEG_A..SEG_G  bit positions inside seg[6:0] ({a,b,c,d,e,f,g})
//           GLYPH_0..GLYPH_F  active-high segment patterns for hex digits
//           hex_to_glyph()    value -> pattern lookup
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational 7-segment pattern to hex value decoder
//
// Purpose: reverse lookup of the shared glyph table.
// Ports:   seg_i    [6:0] segment pattern, {a,b,c,d,e,f,g}, active-high
//          legal_o        pattern is one of the sixteen hex glyphs
//          value_o  [3:0] decoded value (0 when not legal)
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic [3:0] value_o
);

  // All sixteen glyphs are distinct, so at most one table entry can match.
  always_comb begin
    legal_o = 1'b0;
    value_o = 4'h0;
    for (int v = 0; v < 16; v++) begin
      if (seg_i == hex_to_glyph(4'(v))) begin
        legal_o = 1'b1;
        value_o = 4'(v);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus monitor rebuilding per-digit values
//
// Purpose: samples {an,seg}; once a one-hot pattern has been identical for
//          STABLE consecutive clocks it is captured once into the selected digit.
// Ports:   clk        system clock, rising edge
//          rst_n      asynchronous active-low reset
//          seg  [6:0] segment lines {a,b,c,d,e,f,g}, active-high
//          an   [NDIG-1:0] digit enables, active-high, expected one-hot
//          digits [4*NDIG-1:0] decoded value per digit, digit i at [4i+3:4i]
//          dig_valid [NDIG-1:0] sticky: digit i has received a legal capture
//          upd        one-cycle pulse, legal capture written
//          err        one-cycle pulse, stable pattern was not a legal glyph
//          upd_idx    digit index of the current upd/err pulse
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter  int NDIG   = 4,
  parameter  int STABLE = 3,
  localparam int IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic [NDIG-1:0]      an,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      dig_valid,
  output logic                 upd,
  output logic                 err,
  output logic [IDXW-1:0]      upd_idx
);

  localparam int             CW        = $clog2(STABLE + 1);
  localparam logic [CW-1:0]  CNT_SAT   = CW'(STABLE);
  localparam logic [CW-1:0]  CNT_CAPT  = CW'(STABLE - 1);

  logic [NDIG+6:0]   samp_q, samp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   dig_valid_q, dig_valid_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic [IDXW-1:0]   upd_idx_q, upd_idx_d;

  logic              onehot;
  logic              same;
  logic              capture;
  logic [IDXW-1:0]   idx;
  logic              legal;
  logic [3:0]        value;

  seg7_glyph_decode u_decode (
    .seg_i   (seg),
    .legal_o (legal),
    .value_o (value)
  );

  assign onehot  = (an != '0) && ((an & (an - 1'b1)) == '0);
  assign same    = ({an, seg} == samp_q);
  // cnt saturates at STABLE, so the STABLE-1 compare fires only once per run.
  assign capture = onehot && same && (cnt_q == CNT_CAPT);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an[i]) idx = IDXW'(i);
    end
  end

  always_comb begin
    samp_d      = {an, seg};
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    dig_valid_d = dig_valid_q;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    upd_idx_d   = upd_idx_q;

    if (!onehot) begin
      cnt_d = '0;
    end else if (same) begin
      cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
    end else begin
      cnt_d = CW'(1);
    end

    if (capture) begin
      upd_idx_d = idx;
      if (legal) begin
        upd_d = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
          if (an[i]) begin
            digits_d[4*i +: 4] = value;
            dig_valid_d[i]     = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q      <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      dig_valid_q <= '0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      upd_idx_q   <= '0;
    end else begin
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      dig_valid_q <= dig_valid_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
      upd_idx_q   <= upd_idx_d;
    end
  end

  assign digits    = digits_q;
  assign dig_valid = dig_valid_q;
  assign upd       = upd_q;
  assign err       = err_q;
  assign upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        upd;
  logic        err;
  logic [1:0]  upd_idx;

  int passed;
  int total;

  seg7_scan_decoder #(.NDIG(4), .STABLE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .digits    (digits),
    .dig_valid (dig_valid),
    .upd       (upd),
    .err       (err),
    .upd_idx   (upd_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an    = 4'b0001;
    seg   = 7'b1111001;
    step();
    an  = 4'b0101;
    seg = 7'b1111111;
    step();
    an  = 4'b0001;
    seg = 7'b1111001;
    step();
    total++;
    if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits);
    else passed++;
    total++;
    if (dig_valid !== 4'b0000) $display("FAIL reset_dig_valid: got %b want 0000", dig_valid);
    else passed++;
    total++;
    if ({upd, err} !== 2'b00) $display("FAIL reset_pulses: got upd=%b err=%b want 0 0", upd, err);
    else passed++;
    rst_n = 1'b1;
    step();
    total++;
    if (upd !== 1'b0) $display("FAIL first_edge0_upd: got %b want 0", upd);
    else passed++;
    step();
    total++;
    if (upd !== 1'b0) $display("FAIL first_edge1_upd: got %b want 0", upd);
    else passed++;
    step();
    total++;
    if (upd !== 1'b1 || upd_idx !== 2'd0) $display("FAIL first_capture: got upd=%b idx=%0d want 1 0", upd, upd_idx);
    else passed++;
    total++;
    if (digits[3:0] !== 4'h3 || dig_valid !== 4'b0001) $display("FAIL first_value: got d0=%h valid=%b want 3 0001", digits[3:0], dig_valid);
    else passed++;
    step();
    total++;
    if (upd !== 1'b0) $display("FAIL first_pulse_end: got upd=%b want 0", upd);
    else passed++;
  endtask

  task automatic test_full_scan();
    logic [6:0] glyphs [4];
    int pulses;
    int last_idx;
    glyphs[0] = 7'b1111110;
    glyphs[1] = 7'b0110000;
    glyphs[2] = 7'b1110111;
    glyphs[3] = 7'b1000111;
    for (int d = 0; d < 4; d++) begin
      pulses   = 0;
      last_idx = -1;
      an  = 4'(1 << d);
      seg = glyphs[d];
      for (int c = 0; c < 4; c++) begin
        step();
        if (upd === 1'b1) begin
          pulses++;
          last_idx = int'(upd_idx);
        end
      end
      an = 4'b0000;
      step();
      total++;
      if (pulses != 1 || last_idx != d) $display("FAIL scan_digit%0d: got pulses=%0d idx=%0d want 1 %0d", d, pulses, last_idx, d);
      else passed++;
    end
    total++;
    if (digits !== 16'hFA10) $display("FAIL scan_digits: got %h want fa10", digits);
    else passed++;
    total++;
    if (dig_valid !== 4'b1111) $display("FAIL scan_valid: got %b want 1111", dig_valid);
    else passed++;
  endtask

  task automatic test_glitch();
    int early;
    early = 0;
    an  = 4'b0010;
    seg = 7'b1011011;
    for (int c = 0; c < 2; c++) begin
      step();
      if (upd === 1'b1 || err === 1'b1) early++;
    end
    seg = 7'b1011111;
    for (int c = 0; c < 2; c++) begin
      step();
      if (upd === 1'b1 || err === 1'b1) early++;
    end
    total++;
    if (early != 0) $display("FAIL glitch_early: got %0d pulses want 0", early);
    else passed++;
    step();
    total++;
    if (upd !== 1'b1 || upd_idx !== 2'd1 || digits[7:4] !== 4'h6) $display("FAIL glitch_capture: got upd=%b idx=%0d d1=%h want 1 1 6", upd, upd_idx, digits[7:4]);
    else passed++;
  endtask

  task automatic test_illegal();
    int pulses;
    an  = 4'b0100;
    seg = 7'b0000001;
    step();
    step();
    total++;
    if (err !== 1'b0) $display("FAIL illegal_early: got err=%b want 0", err);
    else passed++;
    step();
    total++;
    if (err !== 1'b1 || upd !== 1'b0 || upd_idx !== 2'd2) $display("FAIL illegal_err: got err=%b upd=%b idx=%0d want 1 0 2", err, upd, upd_idx);
    else passed++;
    total++;
    if (digits[11:8] !== 4'hA || dig_valid !== 4'b1111) $display("FAIL illegal_keep: got d2=%h valid=%b want a 1111", digits[11:8], dig_valid);
    else passed++;
    step();
    total++;
    if (err !== 1'b0) $display("FAIL illegal_pulse_end: got err=%b want 0", err);
    else passed++;
    pulses = 0;
    an  = 4'b0110;
    seg = 7'b1011011;
    for (int c = 0; c < 5; c++) begin
      step();
      if (upd === 1'b1 || err === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL bad_enable: got %0d pulses want 0", pulses);
    else passed++;
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    an  = 4'b1000;
    seg = 7'b1111111;
    for (int c = 0; c < 10; c++) begin
      step();
      if (upd === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1 || digits[15:12] !== 4'h8) $display("FAIL saturate: got pulses=%0d d3=%h want 1 8", pulses, digits[15:12]);
    else passed++;
    an = 4'b0000;
    step();
    an = 4'b1000;
    step();
    step();
    total++;
    if (upd !== 1'b0) $display("FAIL repeat_early: got upd=%b want 0", upd);
    else passed++;
    step();
    total++;
    if (upd !== 1'b1 || upd_idx !== 2'd3) $display("FAIL repeat_capture: got upd=%b idx=%0d want 1 3", upd, upd_idx);
    else passed++;
  endtask

  task automatic test_async_reset();
    int pulses;
    an  = 4'b0000;
    step();
    an  = 4'b0001;
    seg = 7'b1111011;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (digits !== 16'h0000 || dig_valid !== 4'b0000) $display("FAIL async_clear: got digits=%h valid=%b want 0000 0000", digits, dig_valid);
    else passed++;
    total++;
    if ({upd, err, upd_idx} !== 4'b0000) $display("FAIL async_pulses: got upd=%b err=%b idx=%0d want 0 0 0", upd, err, upd_idx);
    else passed++;
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (upd === 1'b1 || err === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL async_no_pulse: got %0d pulses want 0", pulses);
    else passed++;
    step();
    total++;
    if (upd !== 1'b1 || digits[3:0] !== 4'h9 || dig_valid !== 4'b0001) $display("FAIL async_restart: got upd=%b d0=%h valid=%b want 1 9 0001", upd, digits[3:0], dig_valid);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    an     = 4'b0000;
    seg    = 7'b0000000;
    test_reset();
    test_full_scan();
    test_glitch();
    test_illegal();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
